demux2_stream_buf: RTL and testbench
====================================

Name: demux2_stream_buf

Overview:
- Sequential counterpart to the 2:1 select mux: takes one valid/ready message stream and steers each message, by a per-message select bit, into one of two buffered output streams.
- Each output has its own 2-entry FIFO. A stall on one output does not block traffic bound for the other.
- Used to split a shared producer (e.g. a memory response or writeback path in the TinyRV1 datapath) between two consumers.

Parameters:
- NBITS, 32, message width in bits (legal range 1 to 64)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_val  input  1  input message valid
- in_rdy  output  1  input ready for the queue selected by in_sel
- in_sel  input  1  destination: 0 routes to out0, 1 routes to out1; sampled only when in_val=1
- in_msg  input  NBITS  input message payload
- out0_val  output  1  out0 queue non-empty
- out0_rdy  input  1  out0 consumer ready
- out0_msg  output  NBITS  head entry of out0 queue
- out1_val  output  1  out1 queue non-empty
- out1_rdy  input  1  out1 consumer ready
- out1_msg  output  NBITS  head entry of out1 queue
- out0_count  output  2  occupancy of out0 queue (0..2)
- out1_count  output  2  occupancy of out1 queue (0..2)

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst=1, regardless of clk, all of the following hold:
  - both queues are empty, so count=0 and val=0
  - read and write pointers are 0
  - all storage entries are 0, so out0_msg and out1_msg are 0
  - in_rdy follows the empty queues, i.e. in_rdy=1
- Reset mid-operation: buffered messages are discarded immediately and not delivered. The first rising edge with rst=0 may perform a transfer.
- Transfer rules: a transfer happens on a port when val=1 and rdy=1 at a rising edge.
  - Input transfer: enqueues in_msg at the write pointer of queue[in_sel], then increments that write pointer (1 bit, wraps 1 to 0) and that count.
  - Output transfer: advances the read pointer (1 bit, wraps) and decrements the count.
- in_rdy is combinational: in_rdy = (queue[in_sel] count != 2).
  - It depends on in_sel and on no other input.
  - It does not depend on the other queue.
  - It does not depend on out*_rdy: there is no pipelined ready, so a full queue refuses an enqueue even when it dequeues in the same cycle.
- outN_val = (countN != 0). outN_msg = storage[read pointer N]. Both are registered-state outputs, with no combinational path from the in_* ports.
- Latency: a message accepted at edge k is visible on outN_val/outN_msg after edge k. There is no bypass, so minimum latency is 1 cycle.
- Simultaneous enqueue and dequeue on the same queue (count 1): count is unchanged and both pointers advance. The old head leaves and the new entry becomes the head after the edge.
- Simultaneous events on both queues: an out0 dequeue, an out1 dequeue and an enqueue to either queue may all occur in one cycle, and each updates independently.
- Ordering: each queue is strict FIFO. No ordering is guaranteed between out0 and out1.
- Input stability:
  - Once in_val=1 is asserted, in_msg and in_sel must not change until the transfer; a bench assertion checks this.
  - The block must not rely on it: an undriven in_sel when in_val=0 has no effect on state.
- Full with no dequeue: in_rdy=0 for that destination and state is held. No message is dropped or overwritten.
- Count encoding: countN never exceeds 2, and the value 3 is unreachable; an assertion flags it.
- No X-propagation is permitted from storage to out*_msg after reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → out0_val=out1_val=0, out0_msg=out1_msg=0, counts 0, in_rdy=1 for in_sel 0 and 1.
- Single route: send 0xDEADBEEF with sel=1, out1_rdy=1 → out1_val=1 with msg 0xDEADBEEF the cycle after acceptance, dequeued next edge, out0_val stays 0.
- Fill and backpressure: out0_rdy=0, send 0x1, 0x2, 0x3 with sel=0 →
  - 0x1 and 0x2 are accepted; out0_count=2.
  - in_rdy=0 for sel=0 while in_rdy=1 for sel=1, and 0x3 is held.
  - Raising out0_rdy drains 0x1 then 0x2, then 0x3 is accepted; order is 0x1, 0x2, 0x3.
- Non-blocking split: out0 stalled and full; stream 0xA0..0xA7 to sel=1 with out1_rdy=1 → all eight arrive on out1 in order at one message per cycle; out0 is unaffected.
- Simultaneous enq/deq with pointer wrap: out0_count=1, out0_rdy=1, stream 0x10..0x17 with sel=0 every cycle → count stays 1 and all arrive in order across several wraps. Separately, at count 2 with out0_rdy=1, in_rdy for sel=0 stays 0 in that cycle.
- Mid-operation reset: both queues hold 2 entries; pulse rst asynchronously between clock edges → counts and vals drop to 0 without a clock edge. The old messages never appear, and the post-reset message 0x55 with sel=0 is delivered correctly.

Source files
------------

// File: rtl/demux2_stream_buf.sv
`default_nettype none
//==============================================================================
// Module   : demux2_stream_buf
// Purpose  : Steers a single valid/ready message stream into one of two
//            buffered output streams, chosen per message by in_sel. Each
//            output owns a 2-entry FIFO, so a stalled consumer on one side
//            never blocks traffic heading for the other side.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            in_val/in_rdy      - input handshake (in_rdy reflects the queue
//                                 addressed by in_sel)
//            in_sel, in_msg     - destination select and payload
//            outN_val/outN_rdy  - output handshakes (N = 0, 1)
//            outN_msg           - head entry of queue N
//            outN_count         - occupancy of queue N (0..2)
// Revision : 1.0 - initial release
//==============================================================================
module demux2_stream_buf #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_sel,
    input  logic [NBITS-1:0] in_msg,
    output logic             out0_val,
    input  logic             out0_rdy,
    output logic [NBITS-1:0] out0_msg,
    output logic             out1_val,
    input  logic             out1_rdy,
    output logic [NBITS-1:0] out1_msg,
    output logic [1:0]       out0_count,
    output logic [1:0]       out1_count
);

    localparam logic [1:0] c_FULL  = 2'd2;
    localparam logic [1:0] c_EMPTY = 2'd0;

    logic [1:0]             w_enq;
    logic [1:0]             w_deq;
    logic [1:0]             w_out_rdy;
    logic [1:0][1:0]        w_count;
    logic [1:0][NBITS-1:0]  w_head;

    assign w_out_rdy = {out1_rdy, out0_rdy};

    // Ready looks only at the addressed queue's occupancy. Output ready is
    // deliberately excluded: a full queue refuses an enqueue even in a cycle
    // where it also dequeues, which keeps in_rdy free of consumer paths.
    assign in_rdy = in_sel ? (w_count[1] != c_FULL) : (w_count[0] != c_FULL);

    assign w_enq[0] = in_val & ~in_sel & in_rdy;
    assign w_enq[1] = in_val &  in_sel & in_rdy;

    for (genvar q = 0; q < 2; q++) begin : g_queue
        logic [NBITS-1:0] r_mem [2];
        logic             r_wp;
        logic             r_rp;
        logic [1:0]       r_count;

        assign w_deq[q] = (r_count != c_EMPTY) & w_out_rdy[q];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // Storage is cleared too so the head output is never X.
                r_mem[0] <= '0;
                r_mem[1] <= '0;
                r_wp     <= 1'b0;
                r_rp     <= 1'b0;
                r_count  <= c_EMPTY;
            end else begin
                if (w_enq[q]) begin
                    r_mem[r_wp] <= in_msg;
                    r_wp        <= ~r_wp;
                end
                if (w_deq[q]) begin
                    r_rp <= ~r_rp;
                end
                // Enqueue and dequeue together leave the count unchanged.
                case ({w_enq[q], w_deq[q]})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end

        assign w_head[q]  = r_mem[r_rp];
        assign w_count[q] = r_count;
    end

    assign out0_val   = (w_count[0] != c_EMPTY);
    assign out1_val   = (w_count[1] != c_EMPTY);
    assign out0_msg   = w_head[0];
    assign out1_msg   = w_head[1];
    assign out0_count = w_count[0];
    assign out1_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_stream_buf.sv
`default_nettype none
//==============================================================================
// Module   : tb_demux2_stream_buf
// Purpose  : Self-checking bench for demux2_stream_buf. A queue-based model
//            tracks what each output FIFO should hold; directed scenarios and
//            a randomized run compare the DUT against it.
// Revision : 1.0 - initial release
//==============================================================================
module tb_demux2_stream_buf;

    logic        clk;
    logic        rst;
    logic        in_val;
    logic        in_rdy;
    logic        in_sel;
    logic [31:0] in_msg;
    logic        out0_val;
    logic        out0_rdy;
    logic [31:0] out0_msg;
    logic        out1_val;
    logic        out1_rdy;
    logic [31:0] out1_msg;
    logic [1:0]  out0_count;
    logic [1:0]  out1_count;

    int total;
    int bad;

    // Reference model: one plain FIFO per output.
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    bit          last_acc;

    demux2_stream_buf #(.NBITS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_sel     (in_sel),
        .in_msg     (in_msg),
        .out0_val   (out0_val),
        .out0_rdy   (out0_rdy),
        .out0_msg   (out0_msg),
        .out1_val   (out1_val),
        .out1_rdy   (out1_rdy),
        .out1_msg   (out1_msg),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input must hold steady while a transfer is pending.
    logic        p_pend;
    logic [31:0] p_msg;
    logic        p_sel;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_pend <= 1'b0;
        end else begin
            if (p_pend)
                assert (in_val && in_msg == p_msg && in_sel == p_sel)
                    else $error("input changed while stalled");
            assert (out0_count != 2'd3) else $error("out0_count reached 3");
            assert (out1_count != 2'd3) else $error("out1_count reached 3");
            p_pend <= in_val && !in_rdy;
            p_msg  <= in_msg;
            p_sel  <= in_sel;
        end
    end

    // Advance one clock, applying the model's view of the transfers.
    task automatic tick();
        bit          enq;
        bit          d0;
        bit          d1;
        bit          s;
        logic [31:0] m;
        s   = in_sel;
        m   = in_msg;
        enq = in_val && ((s ? mq1.size() : mq0.size()) != 2);
        d0  = out0_rdy && (mq0.size() != 0);
        d1  = out1_rdy && (mq1.size() != 0);
        @(posedge clk);
        if (d0) void'(mq0.pop_front());
        if (d1) void'(mq1.pop_front());
        if (enq) begin
            if (s) mq1.push_back(m);
            else   mq0.push_back(m);
        end
        last_acc = enq;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_val = 1'b0; in_sel = 1'b0; in_msg = '0;
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        #1;
        total++;
        if (out0_count !== 2'd0 || out1_count !== 2'd0) begin
            bad++; $display("FAIL reset_counts_during got=%0d/%0d exp=0/0", out0_count, out1_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq0.delete(); mq1.delete();
        #1;
        total++;
        if (out0_val !== 1'b0 || out1_val !== 1'b0) begin
            bad++; $display("FAIL reset_vals got=%b%b exp=00", out0_val, out1_val);
        end
        total++;
        if (out0_msg !== 32'h0 || out1_msg !== 32'h0) begin
            bad++; $display("FAIL reset_msgs got=%h/%h exp=0/0", out0_msg, out1_msg);
        end
        total++;
        if (out0_count !== 2'd0 || out1_count !== 2'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", out0_count, out1_count);
        end
        total++;
        if (in_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_in_rdy_sel0 got=%b exp=1", in_rdy);
        end
        in_sel = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_in_rdy_sel1 got=%b exp=1", in_rdy);
        end
        in_sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_route();
        out0_rdy = 1'b0; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b1; in_msg = 32'hDEADBEEF;
        #1;
        total++;
        if (in_rdy !== 1'b1 || out1_val !== 1'b0) begin
            bad++; $display("FAIL single_pre got rdy=%b val1=%b exp rdy=1 val1=0", in_rdy, out1_val);
        end
        tick();
        in_val = 1'b0;
        #1;
        total++;
        if (out1_val !== 1'b1 || out1_msg !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_out1 got val=%b msg=%h exp val=1 msg=deadbeef", out1_val, out1_msg);
        end
        total++;
        if (out0_val !== 1'b0 || out1_count !== 2'd1) begin
            bad++; $display("FAIL single_side got val0=%b cnt1=%0d exp val0=0 cnt1=1", out0_val, out1_count);
        end
        tick();
        #1;
        total++;
        if (out1_val !== 1'b0 || out0_val !== 1'b0) begin
            bad++; $display("FAIL single_drained got val1=%b val0=%b exp 0/0", out1_val, out0_val);
        end
    endtask

    task automatic test_fill_backpressure();
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 32'h1;
        tick();
        in_msg = 32'h2;
        tick();
        in_msg = 32'h3;
        #1;
        total++;
        if (out0_count !== 2'd2 || in_rdy !== 1'b0) begin
            bad++; $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=2 rdy=0", out0_count, in_rdy);
        end
        in_sel = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++; $display("FAIL fill_other_rdy got=%b exp=1", in_rdy);
        end
        in_sel = 1'b0;
        tick();
        #1;
        total++;
        if (out0_count !== 2'd2 || out0_msg !== 32'h1) begin
            bad++; $display("FAIL fill_held got cnt=%0d msg=%h exp cnt=2 msg=1", out0_count, out0_msg);
        end
        // Full queue with consumer ready: still refuses in this cycle.
        out0_rdy = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b0) begin
            bad++; $display("FAIL full_deq_rdy got=%b exp=0", in_rdy);
        end
        tick();
        #1;
        total++;
        if (out0_msg !== 32'h2 || out0_count !== 2'd1 || in_rdy !== 1'b1) begin
            bad++; $display("FAIL drain_2 got msg=%h cnt=%0d rdy=%b exp msg=2 cnt=1 rdy=1", out0_msg, out0_count, in_rdy);
        end
        tick();
        in_val = 1'b0;
        #1;
        total++;
        if (out0_msg !== 32'h3 || out0_count !== 2'd1) begin
            bad++; $display("FAIL drain_3 got msg=%h cnt=%0d exp msg=3 cnt=1", out0_msg, out0_count);
        end
        tick();
        #1;
        total++;
        if (out0_val !== 1'b0) begin
            bad++; $display("FAIL drain_empty got val=%b exp=0", out0_val);
        end
    endtask

    task automatic test_nonblocking_split();
        out0_rdy = 1'b0; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 32'hB0;
        tick();
        in_msg = 32'hB1;
        tick();
        in_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_msg = 32'hA0 + 32'(i);
            #1;
            total++;
            if (in_rdy !== 1'b1) begin
                bad++; $display("FAIL split_rdy i=%0d got=%b exp=1", i, in_rdy);
            end
            if (i > 0) begin
                total++;
                if (out1_val !== 1'b1 || out1_msg !== 32'hA0 + 32'(i - 1)) begin
                    bad++; $display("FAIL split_out1 i=%0d got val=%b msg=%h exp val=1 msg=%h",
                                    i, out1_val, out1_msg, 32'hA0 + 32'(i - 1));
                end
            end
            total++;
            if (out0_count !== 2'd2 || out0_msg !== 32'hB0) begin
                bad++; $display("FAIL split_out0 i=%0d got cnt=%0d msg=%h exp cnt=2 msg=b0", i, out0_count, out0_msg);
            end
            tick();
        end
        in_val = 1'b0;
        #1;
        total++;
        if (out1_msg !== 32'hA7 || out1_count !== 2'd1) begin
            bad++; $display("FAIL split_last got msg=%h cnt=%0d exp msg=a7 cnt=1", out1_msg, out1_count);
        end
        out0_rdy = 1'b1;
        tick();
        tick();
        #1;
        total++;
        if (out0_val !== 1'b0 || out1_val !== 1'b0) begin
            bad++; $display("FAIL split_drained got %b%b exp 00", out0_val, out1_val);
        end
    endtask

    task automatic test_simul_wrap();
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 32'h0F;
        tick();
        out0_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_msg = 32'h10 + 32'(i);
            #1;
            total++;
            if (out0_count !== 2'd1 || in_rdy !== 1'b1 ||
                out0_msg !== ((i == 0) ? 32'h0F : 32'h10 + 32'(i - 1))) begin
                bad++; $display("FAIL wrap i=%0d got cnt=%0d rdy=%b msg=%h exp cnt=1 rdy=1 msg=%h",
                                i, out0_count, in_rdy, out0_msg,
                                (i == 0) ? 32'h0F : 32'h10 + 32'(i - 1));
            end
            tick();
        end
        in_val = 1'b0;
        #1;
        total++;
        if (out0_msg !== 32'h17 || out0_count !== 2'd1) begin
            bad++; $display("FAIL wrap_last got msg=%h cnt=%0d exp msg=17 cnt=1", out0_msg, out0_count);
        end
        tick();
    endtask

    task automatic test_midop_reset();
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 32'hC0; tick();
        in_msg = 32'hC1; tick();
        in_sel = 1'b1; in_msg = 32'hD0; tick();
        in_msg = 32'hD1; tick();
        in_val = 1'b0;
        #1;
        total++;
        if (out0_count !== 2'd2 || out1_count !== 2'd2) begin
            bad++; $display("FAIL midrst_pre got %0d/%0d exp 2/2", out0_count, out1_count);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (out0_count !== 2'd0 || out1_count !== 2'd0 || out0_val !== 1'b0 || out1_val !== 1'b0) begin
            bad++; $display("FAIL midrst_async got cnt=%0d/%0d val=%b%b exp 0/0 00",
                            out0_count, out1_count, out0_val, out1_val);
        end
        total++;
        if (out0_msg !== 32'h0 || out1_msg !== 32'h0 || in_rdy !== 1'b1) begin
            bad++; $display("FAIL midrst_msgs got %h/%h rdy=%b exp 0/0 rdy=1", out0_msg, out1_msg, in_rdy);
        end
        mq0.delete(); mq1.delete();
        @(negedge clk);
        rst = 1'b0;
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 32'h55;
        tick();
        in_val = 1'b0;
        #1;
        total++;
        if (out0_val !== 1'b1 || out0_msg !== 32'h55 || out1_val !== 1'b0) begin
            bad++; $display("FAIL midrst_post got val0=%b msg=%h val1=%b exp 1 55 0", out0_val, out0_msg, out1_val);
        end
        tick();
        #1;
        total++;
        if (out0_val !== 1'b0 || out1_val !== 1'b0) begin
            bad++; $display("FAIL midrst_drained got %b%b exp 00", out0_val, out1_val);
        end
    endtask

    task automatic test_random();
        int exp_rdy;
        last_acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!(in_val && !last_acc)) begin
                in_val = ($urandom_range(0, 3) != 0);
                in_sel = 1'($urandom_range(0, 1));
                in_msg = $urandom;
            end
            out0_rdy = ($urandom_range(0, 3) != 0);
            out1_rdy = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = ((in_sel ? mq1.size() : mq0.size()) != 2) ? 1 : 0;
            total++;
            if (in_rdy !== 1'(exp_rdy)) begin
                bad++; $display("FAIL rnd_rdy c=%0d got=%b exp=%0d", c, in_rdy, exp_rdy);
            end
            total++;
            if (out0_count !== 2'(mq0.size()) || out1_count !== 2'(mq1.size())) begin
                bad++; $display("FAIL rnd_count c=%0d got=%0d/%0d exp=%0d/%0d",
                                c, out0_count, out1_count, mq0.size(), mq1.size());
            end
            total++;
            if (out0_val !== (mq0.size() != 0) || out1_val !== (mq1.size() != 0)) begin
                bad++; $display("FAIL rnd_val c=%0d got=%b%b", c, out0_val, out1_val);
            end
            if (mq0.size() != 0) begin
                total++;
                if (out0_msg !== mq0[0]) begin
                    bad++; $display("FAIL rnd_msg0 c=%0d got=%h exp=%h", c, out0_msg, mq0[0]);
                end
            end
            if (mq1.size() != 0) begin
                total++;
                if (out1_msg !== mq1[0]) begin
                    bad++; $display("FAIL rnd_msg1 c=%0d got=%h exp=%h", c, out1_msg, mq1[0]);
                end
            end
            tick();
        end
        in_val = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_acc = 1'b1;
        test_reset();
        test_single_route();
        test_fill_backpressure();
        test_nonblocking_split();
        test_simul_wrap();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
